// File: rtl/mas_mul_acc.sv
// mas_mul_acc: signed accumulator for a stream of 64-bit multiplier products.
// A group of len products is summed into an ACC_W-bit register. The result is
// then held with acc_vld until the downstream handshake completes.
// ovf is a sticky flag for signed overflow within the current group.
// ACC_W must be at least 64.
module mas_mul_acc #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             prod_vld,
    input  logic [63:0]      prod,
    output logic             prod_rdy,
    input  logic [CNT_W-1:0] len,
    output logic             acc_vld,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    input  logic             acc_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_live;      // low during reset so prod_rdy stays 0
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_len;
    logic               r_ovf;

    logic               w_accept;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_add_ovf;
    logic [CNT_W-1:0]   w_len_eff;
    logic [CNT_W:0]     w_cnt_inc;   // one bit wider so the compare never wraps
    logic               w_last_acc;

    assign prod_rdy   = r_live && (r_state != S_HOLD);
    assign acc_vld    = (r_state == S_HOLD);
    assign acc        = r_acc;
    assign ovf        = r_ovf;

    assign w_accept   = prod_vld && prod_rdy && !clr;
    assign w_prod_ext = ACC_W'($signed(prod));
    assign w_sum      = r_acc + w_prod_ext;
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_len_eff  = (len == '0) ? CNT_W'(1) : len;
    assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_last_acc = (w_cnt_inc == {1'b0, r_len});

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_len_eff == CNT_W'(1)) ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (w_accept && w_last_acc) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (acc_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (clr) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Accumulator, product counter, latched length and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_live <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_acc <= w_prod_ext;
                    r_cnt <= CNT_W'(1);
                    r_len <= w_len_eff;
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                    r_ovf <= r_ovf || w_add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mas_mul_acc.sv
// tb_mas_mul_acc: directed and random groups driven into a 72-bit and a
// 64-bit accumulator sharing the same inputs, checked against an exact
// integer model of the group sum.
module tb_mas_mul_acc;
    localparam int CNT_W = 8;
    localparam logic signed [127:0] MAX64 = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] MIN64 = -MAX64 - 128'sd1;
    localparam logic signed [127:0] MAX72 = 128'shFF_FFFF_FFFF_FFFF_FFFF >>> 1;
    localparam logic signed [127:0] MIN72 = -MAX72 - 128'sd1;

    logic             clk = 1'b0;
    logic             rstn, clr, prod_vld, acc_rdy;
    logic [63:0]      prod;
    logic [CNT_W-1:0] len;
    logic             rdy72, vld72, ovf72, rdy64, vld64, ovf64;
    logic [71:0]      acc72;
    logic [63:0]      acc64;

    int checks = 0;
    int errors = 0;

    logic signed [127:0] m_sum;
    bit                  m_ovf64, m_ovf72;
    logic [63:0]         pq[$];
    logic [63:0]         pend;

    always #5 clk = ~clk;

    mas_mul_acc #(.ACC_W(72), .CNT_W(CNT_W)) u72 (
        .clk(clk), .rstn(rstn), .clr(clr), .prod_vld(prod_vld), .prod(prod),
        .prod_rdy(rdy72), .len(len), .acc_vld(vld72), .acc(acc72),
        .ovf(ovf72), .acc_rdy(acc_rdy)
    );

    mas_mul_acc #(.ACC_W(64), .CNT_W(CNT_W)) u64 (
        .clk(clk), .rstn(rstn), .clr(clr), .prod_vld(prod_vld), .prod(prod),
        .prod_rdy(rdy64), .len(len), .acc_vld(vld64), .acc(acc64),
        .ovf(ovf64), .acc_rdy(acc_rdy)
    );

    // Exact sum of the group; overflow is any partial sum leaving the signed range.
    function automatic void m_add(input logic [63:0] p, input bit first);
        logic signed [127:0] s;
        s = {{64{p[63]}}, p};
        if (first) begin
            m_sum   = s;
            m_ovf64 = 1'b0;
            m_ovf72 = 1'b0;
        end else begin
            m_sum = m_sum + s;
            if (m_sum > MAX64 || m_sum < MIN64) m_ovf64 = 1'b1;
            if (m_sum > MAX72 || m_sum < MIN72) m_ovf72 = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic exp_rdy, input logic exp_vld);
        chk({tag, " prod_rdy"}, {126'd0, rdy64, rdy72}, {126'd0, exp_rdy, exp_rdy});
        chk({tag, " acc_vld"},  {126'd0, vld64, vld72}, {126'd0, exp_vld, exp_vld});
    endtask

    task automatic chk_result(input string tag);
        chk({tag, " acc72"}, {56'd0, acc72}, {56'd0, m_sum[71:0]});
        chk({tag, " acc64"}, {64'd0, acc64}, {64'd0, m_sum[63:0]});
        chk({tag, " ovf"}, {126'd0, ovf64, ovf72}, {126'd0, m_ovf64, m_ovf72});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " acc72"}, {56'd0, acc72}, 128'd0);
        chk({tag, " acc64"}, {64'd0, acc64}, 128'd0);
        chk({tag, " ovf"}, {126'd0, ovf64, ovf72}, 128'd0);
    endtask

    // Feeds the products in pq as one group; later products carry a random len.
    task automatic run_group(input string tag, input logic [CNT_W-1:0] l,
                             input int gmin, input int gmax, input int hold,
                             input bit vld_on_release);
        int n;
        n = pq.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int gap;
                gap = $urandom_range(gmax, gmin);
                repeat (gap) begin
                    prod_vld = 1'b0;
                    prod     = {$urandom, $urandom};
                    tick;
                    chk_ctl({tag, " gap"}, 1'b1, 1'b0);
                end
            end
            prod     = pq[i];
            prod_vld = 1'b1;
            len      = (i == 0) ? l : CNT_W'($urandom);
            chk({tag, " ready"}, {126'd0, rdy64, rdy72}, 128'd3);
            tick;
            m_add(pq[i], i == 0);
            prod_vld = 1'b0;
            if (i < n - 1) begin
                chk_ctl({tag, " mid"}, 1'b1, 1'b0);
            end else begin
                chk_ctl({tag, " done"}, 1'b0, 1'b1);
                chk_result(tag);
            end
        end
        repeat (hold) begin
            prod_vld = vld_on_release ? 1'b1 : 1'($urandom_range(1, 0));
            prod     = vld_on_release ? pend : {$urandom, $urandom};
            len      = CNT_W'($urandom);
            tick;
            chk_ctl({tag, " hold"}, 1'b0, 1'b1);
            chk_result({tag, " hold"});
        end
        acc_rdy  = 1'b1;
        prod_vld = vld_on_release;
        prod     = pend;
        tick;
        acc_rdy = 1'b0;
        chk_ctl({tag, " release"}, 1'b1, 1'b0);
        pq.delete();
    endtask

    task automatic send_one(input logic [63:0] p, input logic [CNT_W-1:0] l, input bit first);
        prod     = p;
        len      = l;
        prod_vld = 1'b1;
        tick;
        m_add(p, first);
        prod_vld = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; clr = 1'b0; prod_vld = 1'b0; acc_rdy = 1'b0;
        prod = '0; len = '0; pend = '0;
        m_sum = '0; m_ovf64 = 1'b0; m_ovf72 = 1'b0;

        // Reset state and release
        #12;
        chk_ctl("reset", 1'b0, 1'b0);
        chk_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk({"release pre-edge", " prod_rdy"}, {126'd0, rdy64, rdy72}, 128'd0);
        tick;
        chk_ctl("release edge", 1'b1, 1'b0);

        // Single product group
        pq = '{64'd5};
        run_group("single", 8'd1, 0, 0, 0, 1'b0);

        // Signed sum with two idle cycles between products
        pq = '{64'd10, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7};
        run_group("signed", 8'd3, 2, 2, 0, 1'b0);

        // Backpressure: product held upstream through HOLD and the handshake cycle
        pend = {$urandom, $urandom};
        pq = '{{$urandom, $urandom}, {$urandom, $urandom}};
        run_group("bp", 8'd2, 0, 0, 5, 1'b1);
        pq = '{pend};
        run_group("bp_next", 8'd1, 0, 0, 0, 1'b0);
        pend = '0;

        // Positive and negative signed overflow, then a clean group
        pq = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
        run_group("ovf_pos", 8'd2, 0, 0, 1, 1'b0);
        pq = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        run_group("ovf_neg", 8'd2, 0, 1, 0, 1'b0);
        pq = '{64'd5};
        run_group("ovf_next", 8'd1, 0, 0, 0, 1'b0);

        // Abort after two of four products; product with clr is discarded
        send_one({$urandom, $urandom}, 8'd4, 1'b1);
        send_one({$urandom, $urandom}, 8'd4, 1'b0);
        chk_ctl("abort mid", 1'b1, 1'b0);
        clr = 1'b1; prod_vld = 1'b1; prod = {$urandom, $urandom};
        tick;
        clr = 1'b0; prod_vld = 1'b0;
        chk_ctl("abort", 1'b1, 1'b0);
        chk_zero("abort");
        pq = '{64'd3};
        run_group("abort_new", 8'd1, 0, 0, 0, 1'b0);

        // Abort while a result is held
        send_one({$urandom, $urandom}, 8'd1, 1'b1);
        chk_ctl("clr hold pre", 1'b0, 1'b1);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk_ctl("clr hold", 1'b1, 1'b0);
        chk_zero("clr hold");

        // Reset mid-group, then a len=0 group
        send_one({$urandom, $urandom}, 8'd5, 1'b1);
        send_one({$urandom, $urandom}, 8'd5, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk_ctl("rst mid", 1'b0, 1'b0);
        chk_zero("rst mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick;
        chk_ctl("rst release", 1'b1, 1'b0);
        pq = '{{$urandom, $urandom}};
        run_group("len0", 8'd0, 0, 0, 0, 1'b0);

        // Longest group
        for (int i = 0; i < 255; i++) pq.push_back({$urandom, $urandom});
        run_group("len255", 8'd255, 0, 0, 0, 1'b0);

        // Random groups
        for (int g = 0; g < 20; g++) begin
            int n;
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++) pq.push_back({$urandom, $urandom});
            run_group("rand", (n == 1 && $urandom_range(1, 0) == 1) ? 8'd0 : CNT_W'(n),
                      0, 2, $urandom_range(3, 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
